mem_access_ctrl: RTL and testbench

- Sits directly downstream of the instruction sequencer/decoder.
- Turns its level-held `Mem_OE`/`Mem_WE` requests plus the MAR/MDR contents into correctly timed asynchronous-SRAM cycles.
- Returns read data toward the MDR input mux with a one-cycle `Rd_valid` strobe.
- Optionally maps one address to the board switches and hex-display register.

---
 rtl/mem_access_ctrl_if.sv | 38 +++
 rtl/mem_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bundle between the sequencer-side environment and mem_access_ctrl:
// request/response handshake plus the asynchronous-SRAM pad signals.
interface mem_access_ctrl_if;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] Switches;
  logic [15:0] Rd_data;
  logic        Rd_valid;
  logic        Wr_done;
  logic        Busy;
  logic        Err;
  logic [15:0] Hex_out;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic [15:0] SRAM_DQ_in;

  modport master (
    output Mem_OE, Mem_WE, MAR, MDR, Switches, SRAM_DQ_in,
    input  Rd_data, Rd_valid, Wr_done, Busy, Err, Hex_out,
    input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
    input  SRAM_DQ_out, SRAM_DQ_oe
  );

  modport slave (
    input  Mem_OE, Mem_WE, MAR, MDR, Switches, SRAM_DQ_in,
    output Rd_data, Rd_valid, Wr_done, Busy, Err, Hex_out,
    output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
    output SRAM_DQ_out, SRAM_DQ_oe
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequencer-to-async-SRAM access controller with registered strobes.
// Define MEM_IO_MAP_EN to map IO_ADDR onto the switches / hex-display register.
module mem_access_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input logic             Clk,
  input logic             Reset_n,
  mem_access_ctrl_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE
`ifdef MEM_IO_MAP_EN
    , IO_ACC
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        wr_done_q, wr_done_d;
  logic        err_q, err_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, byte_n_q, byte_n_d;
  logic        dq_oe_q, dq_oe_d;
`ifdef MEM_IO_MAP_EN
  logic        is_rd_q, is_rd_d;
  logic [15:0] hex_q, hex_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    err_d      = err_q;
`ifdef MEM_IO_MAP_EN
    is_rd_d    = is_rd_q;
    hex_d      = hex_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Mem_OE || bus.Mem_WE) begin
          addr_d = bus.MAR;
          if (bus.Mem_OE && bus.Mem_WE) err_d = 1'b1;
          if (!bus.Mem_OE) wdata_d = bus.MDR;
`ifdef MEM_IO_MAP_EN
          is_rd_d = bus.Mem_OE;
          if (bus.MAR == IO_ADDR) state_d = IO_ACC;
          else
`endif
          if (bus.Mem_OE) begin
            state_d = RD_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = WR_SETUP;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rd_data_d  = bus.SRAM_DQ_in;
          rd_valid_d = 1'b1;
          state_d    = DONE;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_INIT;
      end
      WR_PULSE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = WR_HOLD;
      end
      WR_HOLD: begin
        wr_done_d = 1'b1;
        state_d   = DONE;
      end
`ifdef MEM_IO_MAP_EN
      IO_ACC: begin
        if (is_rd_q) begin
          rd_data_d  = bus.Switches;
          rd_valid_d = 1'b1;
        end else begin
          hex_d     = wdata_q;
          wr_done_d = 1'b1;
        end
        state_d = DONE;
      end
`endif
      // Wait for the sequencer to drop its level request so it is not serviced twice.
      DONE:    if (!bus.Mem_OE && !bus.Mem_WE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the pads change on the same edge as the state.
  always_comb begin
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    byte_n_d = 1'b1;
    dq_oe_d  = 1'b0;
    case (state_d)
      RD_WAIT:  begin ce_n_d = 1'b0; oe_n_d = 1'b0; byte_n_d = 1'b0; end
      WR_SETUP: begin ce_n_d = 1'b0; byte_n_d = 1'b0; dq_oe_d = 1'b1; end
      WR_PULSE: begin ce_n_d = 1'b0; byte_n_d = 1'b0; dq_oe_d = 1'b1; we_n_d = 1'b0; end
      WR_HOLD:  begin ce_n_d = 1'b0; byte_n_d = 1'b0; dq_oe_d = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 16'h0;
      wdata_q    <= 16'h0;
      rd_data_q  <= 16'h0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      err_q      <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      byte_n_q   <= 1'b1;
      dq_oe_q    <= 1'b0;
`ifdef MEM_IO_MAP_EN
      is_rd_q    <= 1'b0;
      hex_q      <= 16'h0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      err_q      <= err_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      byte_n_q   <= byte_n_d;
      dq_oe_q    <= dq_oe_d;
`ifdef MEM_IO_MAP_EN
      is_rd_q    <= is_rd_d;
      hex_q      <= hex_d;
`endif
    end
  end

  assign bus.Rd_data     = rd_data_q;
  assign bus.Rd_valid    = rd_valid_q;
  assign bus.Wr_done     = wr_done_q;
  assign bus.Busy        = (state_q != IDLE);
  assign bus.Err         = err_q;
  assign bus.SRAM_ADDR   = {4'h0, addr_q};
  assign bus.SRAM_CE_N   = ce_n_q;
  assign bus.SRAM_OE_N   = oe_n_q;
  assign bus.SRAM_WE_N   = we_n_q;
  assign bus.SRAM_UB_N   = byte_n_q;
  assign bus.SRAM_LB_N   = byte_n_q;
  assign bus.SRAM_DQ_out = wdata_q;
  assign bus.SRAM_DQ_oe  = dq_oe_q;
`ifdef MEM_IO_MAP_EN
  assign bus.Hex_out     = hex_q;
`else
  logic [31:0] unused_io;
  assign unused_io   = {bus.Switches, IO_ADDR};
  assign bus.Hex_out = 16'h0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural async-SRAM model
// (commits on the rising edge of WE_N while out of reset).
module tb_mem_access_ctrl;

  logic Clk = 1'b0;
  logic Reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.WAIT_CYCLES(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  logic [15:0] mem [0:65535];

  assign bus.SRAM_DQ_in = (!bus.SRAM_CE_N && !bus.SRAM_OE_N) ? mem[bus.SRAM_ADDR[15:0]] : 16'h0;

  always @(posedge bus.SRAM_WE_N)
    if (Reset_n && !bus.SRAM_CE_N && bus.SRAM_DQ_oe)
      mem[bus.SRAM_ADDR[15:0]] = bus.SRAM_DQ_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_UB_N, bus.SRAM_LB_N};
  endfunction

  int we_low, oe_cyc, done_cnt, done_at, rv_cnt;

  initial begin
    mem[16'h3000] = 16'h1234;
    mem[16'h0042] = 16'h0000;
    mem[16'hFFFF] = 16'h5A5A;
    bus.Mem_OE = 0; bus.Mem_WE = 0; bus.MAR = 0; bus.MDR = 0; bus.Switches = 16'h00A5;
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    tick(); tick();
    check("rst_rd_data", bus.Rd_data, 16'h0);
    check("rst_flags", {bus.Rd_valid, bus.Wr_done, bus.Busy, bus.Err}, 4'b0000);
    check("rst_strobes", strobes(), 5'h1F);
    check("rst_addr", bus.SRAM_ADDR, 20'h0);
    check("rst_dq", {bus.SRAM_DQ_oe, bus.SRAM_DQ_out}, 17'h0);
    check("rst_hex", bus.Hex_out, 16'h0);
    Reset_n = 1'b1;
    tick();

    // Read at 0x3000, request held well past completion.
    bus.Mem_OE = 1; bus.MAR = 16'h3000;
    tick(); // E0
    check("rd_e0_addr", bus.SRAM_ADDR, 20'h03000);
    check("rd_e0_strobes", strobes(), 5'b00100);
    check("rd_e0_busy", bus.Busy, 1'b1);
    bus.MAR = 16'h1111;
    tick(); // E1
    check("rd_e1_strobes", strobes(), 5'b00100);
    check("rd_e1_addr_hold", bus.SRAM_ADDR, 20'h03000);
    check("rd_e1_valid", bus.Rd_valid, 1'b0);
    tick(); // E2
    check("rd_e2_valid", bus.Rd_valid, 1'b1);
    check("rd_e2_data", bus.Rd_data, 16'h1234);
    check("rd_e2_strobes", strobes(), 5'h1F);
    rv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      rv_cnt += int'(bus.Rd_valid);
    end
    check("rd_no_repeat", rv_cnt, 0);
    check("rd_done_busy", bus.Busy, 1'b1);
    bus.Mem_OE = 0;
    tick();
    check("rd_idle_busy", bus.Busy, 1'b0);

    // Write BEEF to 0x42.
    bus.Mem_WE = 1; bus.MAR = 16'h0042; bus.MDR = 16'hBEEF;
    we_low = 0; oe_cyc = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) check("wr_setup_strobes", {strobes(), bus.SRAM_DQ_oe}, 6'b011001);
      if (i == 1) bus.MDR = 16'h5555;
      we_low += int'(!bus.SRAM_WE_N);
      oe_cyc += int'(bus.SRAM_DQ_oe);
      if (bus.Wr_done) begin done_cnt++; done_at = i; end
    end
    check("wr_we_low_cycles", we_low, 2);
    check("wr_dq_oe_cycles", oe_cyc, 4);
    check("wr_done_count", done_cnt, 1);
    check("wr_done_cycle", done_at, 4);
    check("wr_mem", mem[16'h0042], 16'hBEEF);
    bus.Mem_WE = 0;
    tick();
    check("wr_idle_busy", bus.Busy, 1'b0);

    // Simultaneous requests: read wins, Err set and sticky.
    bus.Mem_OE = 1; bus.Mem_WE = 1; bus.MAR = 16'h0042;
    tick();
    check("both_e0_strobes", strobes(), 5'b00100);
    check("both_err", bus.Err, 1'b1);
    tick(); tick();
    check("both_rd_valid", bus.Rd_valid, 1'b1);
    check("both_rd_data", bus.Rd_data, 16'hBEEF);
    bus.Mem_OE = 0; bus.Mem_WE = 0;
    tick(); tick(); tick();
    check("err_sticky", bus.Err, 1'b1);

    // Reset during WR_PULSE aborts the write.
    bus.Mem_WE = 1; bus.MAR = 16'h3000; bus.MDR = 16'hDEAD;
    tick(); tick();
    check("abort_pulse_we", bus.SRAM_WE_N, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    check("abort_strobes", {strobes(), bus.SRAM_DQ_oe}, 6'b111110);
    check("abort_err_clr", bus.Err, 1'b0);
    check("abort_mem", mem[16'h3000], 16'h1234);
    bus.Mem_WE = 0;
    tick();
    Reset_n = 1'b1;
    tick();

    // Access at IO_ADDR.
    bus.Mem_OE = 1; bus.MAR = 16'hFFFF;
`ifdef MEM_IO_MAP_EN
    tick();
    check("io_rd_ce", bus.SRAM_CE_N, 1'b1);
    tick();
    check("io_rd_valid", bus.Rd_valid, 1'b1);
    check("io_rd_data", bus.Rd_data, 16'h00A5);
    check("io_rd_ce_e1", bus.SRAM_CE_N, 1'b1);
    bus.Mem_OE = 0;
    tick(); tick();
    bus.Mem_WE = 1; bus.MDR = 16'h0F0F;
    tick(); tick();
    check("io_wr_done", bus.Wr_done, 1'b1);
    check("io_hex", bus.Hex_out, 16'h0F0F);
    check("io_wr_ce", bus.SRAM_CE_N, 1'b1);
    bus.Mem_WE = 0;
    tick();
`else
    tick();
    check("ffff_addr", bus.SRAM_ADDR, 20'h0FFFF);
    check("ffff_strobes", strobes(), 5'b00100);
    tick(); tick();
    check("ffff_rd_data", bus.Rd_data, 16'h5A5A);
    bus.Mem_OE = 0;
    tick(); tick();
    bus.Mem_WE = 1; bus.MDR = 16'h0F0F;
    for (int i = 0; i < 6; i++) tick();
    check("ffff_wr_mem", mem[16'hFFFF], 16'h0F0F);
    check("ffff_hex", bus.Hex_out, 16'h0);
    bus.Mem_WE = 0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
